// File: rtl/alu_iter_exec.sv
// Iterative ALU: single-cycle add/sub/and/or and a bit-serial shift-left
// that takes one cycle per shift position. Valid/ready handshake on both sides.
module alu_iter_exec #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpSll = 4'b1000;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   acc_shl;

  assign shamt   = b[SHAMT_W-1:0];
  assign acc_shl = {acc_q[WIDTH-2:0], 1'b0};

  // Single-cycle result; an sll reaching here has a zero shift amount, so it passes a through.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpSll:   alu_res = a;
      default: alu_ill = 1'b1;
    endcase
  end

  // Control FSM plus result/accumulator registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (op == OpSll && shamt != '0) begin
              acc_q   <= a;
              cnt_q   <= shamt;
              state_q <= StShift;
            end else begin
              result_q  <= alu_res;
              zero_q    <= (alu_res == '0);
              illegal_q <= alu_ill;
              state_q   <= StDone;
            end
          end
        end
        StShift: begin
          acc_q <= acc_shl;
          cnt_q <= cnt_q - 1'b1;
          // Final shift writes the shifted value straight into the result register.
          if (cnt_q == SHAMT_W'(1)) begin
            result_q  <= acc_shl;
            zero_q    <= (acc_shl == '0);
            illegal_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_iter_exec.md
ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

Interface
REQ-001 Parameter WIDTH, default 64, datapath width in bits; SHAMT_W = log2(WIDTH), 6 at default.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  operation code: 0010 add, 0110 sub, 0000 and, 0001 or, 1000 sll.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand; for sll only b[SHAMT_W-1:0] is the shift amount.
REQ-009 out_valid  output  1  result/zero/illegal are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result is all zeros.
REQ-013 illegal  output  1  high when the accepted op is not one of the five listed codes.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-016 A request SHALL be accepted on a rising edge where state is IDLE and in_valid is 1; op/a/b are ignored at all other times.
REQ-017 On accepting add/sub/and/or: result SHALL be registered at the accept edge, state -> DONE (out_valid high in the following cycle, latency 1).
REQ-018 add = (a+b) mod 2^WIDTH; sub = (a-b) mod 2^WIDTH; carry/borrow discarded.
REQ-019 and/or SHALL be bitwise across WIDTH bits.
REQ-020 On accepting sll with amount n = b[SHAMT_W-1:0]: n=0 -> result=a, state -> DONE, latency 1.
REQ-021 sll with n>=1: accept edge loads accumulator=a, counter=n, state -> SHIFT.
REQ-022 Each SHIFT edge: accumulator shifts left by 1 (zero fill, MSB dropped), counter decrements; the edge where counter goes 1->0 SHALL also move state -> DONE; latency n+1 cycles.
REQ-023 Bits of b above SHAMT_W-1 SHALL NOT affect sll.
REQ-024 Illegal op: result=0, zero=1, illegal=1, state -> DONE, latency 1.
REQ-025 illegal SHALL be 0 for all five legal codes.
REQ-026 zero SHALL be registered together with result and equal (result == 0).
REQ-027 In DONE, result/zero/illegal SHALL hold stable until out_ready=1; the edge with out_ready=1 SHALL move state -> IDLE.
REQ-028 No accept in the DONE->IDLE cycle: minimum spacing between accepts is latency+1 cycles.
REQ-029 out_ready while not in DONE SHALL have no effect.
REQ-030 SHIFT SHALL NOT be interrupted by in_valid or out_ready; only reset aborts it.

Reset
REQ-031 reset=1 at a rising edge SHALL force state=IDLE, result=0, zero=0, illegal=0, accumulator=0, counter=0, from any state.
REQ-032 After reset: in_ready=1, out_valid=0; an in-flight operation SHALL be discarded with no out_valid pulse.
REQ-033 reset SHALL take priority over a simultaneous accept or out_ready.

Verification
REQ-034 add: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op=0010 -> one cycle later out_valid=1, result=0, zero=1, illegal=0.
REQ-035 sub/and/or: a=5,b=7,op=0110 -> result=0xFFFF_FFFF_FFFF_FFFE, zero=0; a=0xF0,b=0x3C,op=0000 -> 0x30; op=0001 -> 0xFC.
REQ-036 sll: a=1, b=0x43 (n=3), op=1000 -> out_valid exactly 4 cycles after accept, result=8; b=0 -> result=a after 1 cycle; a=1,n=63 -> result=0x8000_0000_0000_0000 after 64 cycles.
REQ-037 backpressure: hold out_ready=0 for 5 cycles in DONE -> result/zero stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 illegal: op=1111, a=b=3 -> result=0, zero=1, illegal=1, latency 1.
REQ-039 reset mid-SHIFT: sll n=10, assert reset on 4th SHIFT cycle -> next cycle state IDLE, out_valid=0, result=0, in_ready=1; no stale out_valid afterward.
